cfg_cmd_arbiter: RTL and testbench
==================================

# cfg_cmd_arbiter

- Shares the single CPU configuration command mailbox between two requesters: index 0 = N64 (PI side), index 1 = USB.
- Sequences each command on behalf of the owner: grant, latch, `cmd_request` pulse, busy/idle tracking, response capture and completion.
- Arbitrates round-robin, guards every command with a timeout, and supports aborting an N64-owned command on N64 soft reset.
- Sits between the N64/USB front-ends and the CPU config register block.

## Interface
Parameters:
- TIMEOUT, 50_000_000, cycles allowed from `cmd_request` to CPU done before error completion.
- TW, $clog2(TIMEOUT+1), timeout counter width.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  command request per requester; held until req_ready.
- req_cmd  in  16  [7:0] N64 command, [15:8] USB command.
- req_data  in  128  [63:0] N64 {data1,data0}, [127:64] USB {data1,data0}.
- req_ready  out  2  one-cycle accept pulse per requester.
- req_done  out  2  one-cycle completion pulse per requester.
- req_error  out  1  error status of the last completion; valid with req_done.
- rsp_data  out  64  {data1,data0} captured at completion; held until next completion.
- n64_abort  in  1  N64 soft reset; abandons an N64-owned command.
- cfg_cpu_ready  in  1  CPU mailbox ready.
- cfg_cpu_busy  in  1  CPU processing flag.
- cfg_cmd_error  in  1  CPU command error flag.
- cfg_rdata  in  64  CPU data registers {data1,data0}.
- cfg_cmd_request  out  1  one-cycle command strobe to the config block.
- cfg_cmd  out  8  latched command.
- cfg_data  out  64  latched {data1,data0}.
- owner  out  1  index of the current or most recent grantee.
- busy  out  1  high in every state except IDLE.

## Operation
- All outputs are registered. Reset values: every output 0; internal last_owner = 1, so N64 wins the first tie; state = IDLE; counter = 0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE, RECOVER.

IDLE
- Grants only when `cfg_cpu_ready` = 1 and at least one `req_valid` is set.
- A single valid request wins. When both are valid, the requester that is not last_owner wins.
- On grant: latch cfg_cmd/cfg_data from the winner's slice; set owner and last_owner; pulse req_ready[winner]; go to ISSUE.

ISSUE
- cfg_cmd_request = 1 for exactly this one cycle.
- Clear the counter; go to WAIT_BUSY.

WAIT_BUSY
- Go to WAIT_DONE when cfg_cpu_busy = 1.

WAIT_DONE
- Go to COMPLETE when cfg_cpu_busy = 0.
- On normal completion: rsp_data <= cfg_rdata, req_error <= cfg_cmd_error.

Timeout
- The counter increments in WAIT_BUSY and WAIT_DONE.
- When counter = TIMEOUT-1 and the exit condition is still false: rsp_data <= 0, req_error <= 1, go to COMPLETE.
- If the exit condition and timeout occur in the same cycle, the exit condition wins.

COMPLETE
- Pulse req_done[owner].
- Go to RECOVER if cfg_cpu_busy = 1 (timeout case), otherwise go to IDLE.

RECOVER
- Wait for cfg_cpu_busy = 0, then go to IDLE. Never times out.

n64_abort
- While owner = 0 and state is ISSUE, WAIT_BUSY or WAIT_DONE: go to RECOVER, with no req_done and no change to rsp_data or req_error.
- If n64_abort coincides with the ISSUE cycle, cfg_cmd_request is still emitted.
- Ignored when owner = 1, and ignored in IDLE, COMPLETE and RECOVER.

Requester rule
- A requester must drop req_valid on the cycle after it sees req_ready. Otherwise the arbiter treats the held request as a new one on its next return to IDLE.

## Timing
- Grant decision at edge T: req_ready, cfg_cmd, cfg_data and cfg_cmd_request are all high/valid during cycle T+1.
- State is WAIT_BUSY from T+2.
- Minimum accept-to-done latency, with the CPU raising busy at T+2 and dropping it at T+3: req_done at T+4.
- Back-to-back commands: next grant is possible in the first IDLE cycle after COMPLETE, giving a 5-cycle minimum period.
- cfg_cpu_ready low in IDLE: requests stall indefinitely with no ready pulse.
- reset_n asserted at any time: everything returns to reset values immediately; the in-flight command is lost with no done pulse.

## Test plan
- Single N64 request, cmd 0x43, data {0x1,0x2}: req_ready[0] at T+1 with cfg_cmd = 0x43 and one cfg_cmd_request. CPU busy for 3 cycles with cfg_rdata = 0xAABB_CCDD_0000_0001 -> req_done[0] pulse, req_error = 0, rsp_data matches.
- Both requests valid continuously, re-requesting after each done: grants alternate 0,1,0,1; first grant goes to N64; no grant occurs while busy = 1.
- TIMEOUT = 16 and CPU never raises busy: req_done at 16 cycles after WAIT_BUSY entry, req_error = 1, rsp_data = 0, return to IDLE.
- TIMEOUT = 16 and busy stuck high: error completion, then RECOVER; no new grant until busy falls; USB request pending meanwhile is granted afterwards.
- n64_abort during WAIT_DONE with owner 0: no req_done[0], enters RECOVER, IDLE after busy low. Same abort with owner 1: ignored, completes normally.
- reset_n low mid-WAIT_DONE: all outputs 0 asynchronously. After release, N64 wins a simultaneous request.

Source files
------------

// File: rtl/cfg_cmd_arbiter_if.sv
// Signal bundle between the N64/USB front-ends, the command arbiter and the CPU config block.
// The arbiter uses the slave view; the surrounding environment drives the master view.
interface cfg_cmd_arbiter_if;
    logic [1:0]   req_valid;
    logic [15:0]  req_cmd;
    logic [127:0] req_data;
    logic [1:0]   req_ready;
    logic [1:0]   req_done;
    logic         req_error;
    logic [63:0]  rsp_data;
    logic         n64_abort;
    logic         cfg_cpu_ready;
    logic         cfg_cpu_busy;
    logic         cfg_cmd_error;
    logic [63:0]  cfg_rdata;
    logic         cfg_cmd_request;
    logic [7:0]   cfg_cmd;
    logic [63:0]  cfg_data;
    logic         owner;
    logic         busy;

    modport slave (
        input  req_valid, req_cmd, req_data, n64_abort,
        input  cfg_cpu_ready, cfg_cpu_busy, cfg_cmd_error, cfg_rdata,
        output req_ready, req_done, req_error, rsp_data,
        output cfg_cmd_request, cfg_cmd, cfg_data, owner, busy
    );

    modport master (
        output req_valid, req_cmd, req_data, n64_abort,
        output cfg_cpu_ready, cfg_cpu_busy, cfg_cmd_error, cfg_rdata,
        input  req_ready, req_done, req_error, rsp_data,
        input  cfg_cmd_request, cfg_cmd, cfg_data, owner, busy
    );
endinterface

// File: rtl/cfg_cmd_arbiter.sv
// Round-robin owner of the CPU config command mailbox for the N64 (0) and USB (1) requesters.
// Sequences grant, command strobe, busy tracking, timeout and completion; all outputs registered.
module cfg_cmd_arbiter #(
    parameter int unsigned TIMEOUT = 50_000_000,
    parameter int unsigned TW      = $clog2(TIMEOUT + 1)
) (
    input logic              clk,
    input logic              reset_n,
    cfg_cmd_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StComplete,
        StRecover
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [63:0]   data_q, data_d;
    logic [63:0]   rsp_q, rsp_d;
    logic          err_q, err_d;
    logic [1:0]    ready_q, ready_d;
    logic [1:0]    done_q, done_d;
    logic          request_q, request_d;
    logic          busy_q, busy_d;

    logic winner;
    logic timeout_hit;
    logic abort;

    // On a tie the requester that did not own the previous command wins.
    always_comb begin
        if (bus.req_valid == 2'b11) begin
            winner = ~last_owner_q;
        end else begin
            winner = bus.req_valid[1];
        end
    end

    assign timeout_hit = (cnt_q == TW'(TIMEOUT - 1));
    assign abort       = bus.n64_abort && !owner_q &&
                         (state_q inside {StIssue, StWaitBusy, StWaitDone});

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cmd_d        = cmd_q;
        data_d       = data_q;
        rsp_d        = rsp_q;
        err_d        = err_q;
        ready_d      = 2'b00;

        case (state_q)
            StIdle: begin
                if (bus.cfg_cpu_ready && (bus.req_valid != 2'b00)) begin
                    owner_d      = winner;
                    last_owner_d = winner;
                    cmd_d        = winner ? bus.req_cmd[15:8]    : bus.req_cmd[7:0];
                    data_d       = winner ? bus.req_data[127:64] : bus.req_data[63:0];
                    ready_d      = winner ? 2'b10 : 2'b01;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                cnt_d = cnt_q + TW'(1);
                if (bus.cfg_cpu_busy) begin
                    state_d = StWaitDone;
                end else if (timeout_hit) begin
                    rsp_d   = '0;
                    err_d   = 1'b1;
                    state_d = StComplete;
                end
            end
            StWaitDone: begin
                cnt_d = cnt_q + TW'(1);
                if (!bus.cfg_cpu_busy) begin
                    rsp_d   = bus.cfg_rdata;
                    err_d   = bus.cfg_cmd_error;
                    state_d = StComplete;
                end else if (timeout_hit) begin
                    rsp_d   = '0;
                    err_d   = 1'b1;
                    state_d = StComplete;
                end
            end
            // A timed-out CPU may still be busy; drain it before the next grant.
            StComplete: state_d = bus.cfg_cpu_busy ? StRecover : StIdle;
            StRecover: begin
                if (!bus.cfg_cpu_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // N64 soft reset abandons its command silently: no done, response left untouched.
        if (abort) begin
            state_d = StRecover;
            rsp_d   = rsp_q;
            err_d   = err_q;
        end
    end

    assign done_d    = (state_d == StComplete) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    assign request_d = (state_d == StIssue);
    assign busy_d    = (state_d != StIdle);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cmd_q        <= '0;
            data_q       <= '0;
            rsp_q        <= '0;
            err_q        <= 1'b0;
            ready_q      <= 2'b00;
            done_q       <= 2'b00;
            request_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cmd_q        <= cmd_d;
            data_q       <= data_d;
            rsp_q        <= rsp_d;
            err_q        <= err_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            request_q    <= request_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready       = ready_q;
    assign bus.req_done        = done_q;
    assign bus.req_error       = err_q;
    assign bus.rsp_data        = rsp_q;
    assign bus.cfg_cmd_request = request_q;
    assign bus.cfg_cmd         = cmd_q;
    assign bus.cfg_data        = data_q;
    assign bus.owner           = owner_q;
    assign bus.busy            = busy_q;

endmodule

// File: tb/tb_cfg_cmd_arbiter.sv
// Scoreboard bench for cfg_cmd_arbiter: a small CPU model answers commands with
// rsp = {AABBCCDD, data1} and error = cmd[7]; expected completions are queued per grant.
module tb_cfg_cmd_arbiter;
    localparam int unsigned TO = 16;
    localparam logic [31:0] CpuHi = 32'hAABB_CCDD;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    cfg_cmd_arbiter_if bus ();

    cfg_cmd_arbiter #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        idx;
        logic        err;
        logic [63:0] rsp;
    } done_t;

    done_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cpu_mode = 0;  // 0 normal, 1 never busy, 2 busy until switched to normal
    int          cpu_len = 1;
    logic        mdl_last = 1'b1;
    logic [63:0] mdl_rsp = '0;
    logic        mdl_err = 1'b0;
    logic [7:0]  cur_cmd [2];
    logic [63:0] cur_data [2];

    // CPU model acts 2ns after the edge so it always follows the stimulus tasks.
    initial begin : cpu_model
        bit armed;
        int left;
        armed = 1'b0;
        left = 0;
        bus.cfg_cpu_busy = 1'b0;
        bus.cfg_cmd_error = 1'b0;
        bus.cfg_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.cfg_cpu_busy) begin
                if (cpu_mode == 0) begin
                    if (left <= 1) bus.cfg_cpu_busy = 1'b0;
                    else left--;
                end
            end else if (armed && cpu_mode != 1) begin
                bus.cfg_cpu_busy = 1'b1;
                bus.cfg_rdata = {CpuHi, bus.cfg_data[63:32]};
                bus.cfg_cmd_error = bus.cfg_cmd[7];
                left = (cpu_mode == 2) ? 1 : cpu_len;
            end
            armed = bus.cfg_cmd_request;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    function automatic logic [1:0] oh(input logic i);
        return i ? 2'b10 : 2'b01;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic i, input logic [7:0] cmd, input logic [63:0] data);
        cur_cmd[i] = cmd;
        cur_data[i] = data;
        if (i) begin
            bus.req_cmd[15:8] = cmd;
            bus.req_data[127:64] = data;
        end else begin
            bus.req_cmd[7:0] = cmd;
            bus.req_data[63:0] = data;
        end
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic push_exp(input logic i);
        exp_q.push_back('{idx: i, err: cur_cmd[i][7], rsp: {CpuHi, cur_data[i][63:32]}});
    endtask

    task automatic wait_ready(input int budget, output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            tick();
            n++;
            seen = (bus.req_ready != 2'b00);
        end
    endtask

    task automatic wait_done(input int budget, output int n, output bit seen, output int grants);
        n = 0;
        seen = 1'b0;
        grants = 0;
        while (!seen && n < budget) begin
            tick();
            n++;
            if (bus.req_ready != 2'b00) grants++;
            seen = (bus.req_done != 2'b00);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = '0;
        bus.req_cmd = '0;
        bus.req_data = '0;
        bus.n64_abort = 1'b0;
        bus.cfg_cpu_ready = 1'b1;
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.req_ready, bus.req_done, bus.req_error, bus.cfg_cmd_request, bus.owner, bus.busy}
            !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %h want 00", {bus.req_ready, bus.req_done,
                     bus.req_error, bus.cfg_cmd_request, bus.owner, bus.busy});
        end
        checks++;
        if (bus.rsp_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_rsp: got %h want 0", bus.rsp_data);
        end
        checks++;
        if ({bus.cfg_cmd, bus.cfg_data} !== 72'h0) begin
            errors++;
            $display("FAIL reset_cfg: got %h want 0", {bus.cfg_cmd, bus.cfg_data});
        end
        reset_n = 1'b1;
        mdl_last = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_round_robin();
        int n, g;
        bit seen;
        logic w;
        done_t e;
        cpu_mode = 0;
        cpu_len = 1;
        request(1'b0, 8'h10, {32'h100, 32'h200});
        request(1'b1, 8'h90, {32'h300, 32'h400});
        for (int k = 0; k < 4; k++) begin
            w = ~mdl_last;
            push_exp(w);
            wait_ready(10, n, seen);
            checks++;
            if (!seen || bus.req_ready !== oh(w)) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b want %b", k, bus.req_ready, oh(w));
            end
            checks++;
            if (bus.cfg_cmd !== cur_cmd[w]) begin
                errors++;
                $display("FAIL rr_cmd%0d: got %h want %h", k, bus.cfg_cmd, cur_cmd[w]);
            end
            if (k > 0) begin
                checks++;
                if (n != 2) begin
                    errors++;
                    $display("FAIL rr_period%0d: done-to-ready got %0d want 2", k, n);
                end
            end
            bus.req_valid[w] = 1'b0;
            mdl_last = w;
            wait_done(10, n, seen, g);
            checks++;
            if (!seen || n != 3) begin
                errors++;
                $display("FAIL rr_latency%0d: got %0d cycles (seen %0b) want 3", k, n, seen);
            end
            checks++;
            if (g != 0) begin
                errors++;
                $display("FAIL rr_grant_while_busy%0d: got %0d grants want 0", k, g);
            end
            e = exp_q.pop_front();
            checks++;
            if (bus.req_done !== oh(e.idx)) begin
                errors++;
                $display("FAIL rr_done%0d: got %b want %b", k, bus.req_done, oh(e.idx));
            end
            checks++;
            if (bus.req_error !== e.err || bus.rsp_data !== e.rsp) begin
                errors++;
                $display("FAIL rr_rsp%0d: got %b/%h want %b/%h", k, bus.req_error,
                         bus.rsp_data, e.err, e.rsp);
            end
            mdl_rsp = e.rsp;
            mdl_err = e.err;
            if (k < 3) request(w, cur_cmd[w] + 8'h1, cur_data[w] + {32'h10, 32'h10});
            else bus.req_valid = 2'b00;
        end
    endtask

    task automatic test_single_n64();
        int n, g;
        bit seen;
        done_t e;
        cpu_mode = 0;
        cpu_len = 3;
        request(1'b0, 8'h43, {32'h1, 32'h2});
        exp_q.push_back('{idx: 1'b0, err: 1'b0, rsp: 64'hAABB_CCDD_0000_0001});
        wait_ready(8, n, seen);
        checks++;
        if (!seen || bus.req_ready !== 2'b01 || bus.owner !== 1'b0) begin
            errors++;
            $display("FAIL n64_ready: got %b owner %b want 01 owner 0", bus.req_ready, bus.owner);
        end
        checks++;
        if (bus.cfg_cmd !== 8'h43 || bus.cfg_data !== {32'h1, 32'h2}) begin
            errors++;
            $display("FAIL n64_latch: got %h/%h want 43/%h", bus.cfg_cmd, bus.cfg_data,
                     {32'h1, 32'h2});
        end
        checks++;
        if (bus.cfg_cmd_request !== 1'b1) begin
            errors++;
            $display("FAIL n64_strobe: got %b want 1", bus.cfg_cmd_request);
        end
        bus.req_valid[0] = 1'b0;
        mdl_last = 1'b0;
        tick();
        checks++;
        if (bus.cfg_cmd_request !== 1'b0) begin
            errors++;
            $display("FAIL n64_strobe_once: got %b want 0", bus.cfg_cmd_request);
        end
        wait_done(20, n, seen, g);
        e = exp_q.pop_front();
        checks++;
        if (!seen || bus.req_done !== oh(e.idx)) begin
            errors++;
            $display("FAIL n64_done: got %b want %b", bus.req_done, oh(e.idx));
        end
        checks++;
        if (bus.req_error !== e.err || bus.rsp_data !== e.rsp) begin
            errors++;
            $display("FAIL n64_rsp: got %b/%h want %b/%h", bus.req_error, bus.rsp_data,
                     e.err, e.rsp);
        end
        mdl_rsp = e.rsp;
        mdl_err = e.err;
        tick();
        checks++;
        if (bus.req_done !== 2'b00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL n64_done_pulse: got done %b busy %b want 00/0", bus.req_done, bus.busy);
        end
    endtask

    task automatic test_timeout_idle();
        int n, g;
        bit seen;
        done_t e;
        cpu_mode = 1;
        request(1'b0, 8'h55, {32'h7, 32'h8});
        exp_q.push_back('{idx: 1'b0, err: 1'b1, rsp: 64'h0});
        wait_ready(8, n, seen);
        checks++;
        if (!seen || bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL to_grant: got %b want 01", bus.req_ready);
        end
        bus.req_valid[0] = 1'b0;
        mdl_last = 1'b0;
        wait_done(40, n, seen, g);
        checks++;
        if (!seen || n != TO + 1) begin
            errors++;
            $display("FAIL to_latency: got %0d cycles (seen %0b) want %0d", n, seen, TO + 1);
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.req_done !== oh(e.idx) || bus.req_error !== e.err || bus.rsp_data !== e.rsp) begin
            errors++;
            $display("FAIL to_result: got %b/%b/%h want %b/%b/%h", bus.req_done, bus.req_error,
                     bus.rsp_data, oh(e.idx), e.err, e.rsp);
        end
        mdl_rsp = e.rsp;
        mdl_err = e.err;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL to_idle: got busy %b want 0", bus.busy);
        end
        cpu_mode = 0;
    endtask

    task automatic test_cpu_not_ready();
        int n, g;
        bit seen;
        bit bad;
        done_t e;
        cpu_mode = 0;
        cpu_len = 1;
        bus.cfg_cpu_ready = 1'b0;
        request(1'b0, 8'h21, {32'h5, 32'h6});
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (bus.req_ready !== 2'b00 || bus.busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stall: got ready/busy activity want none while cpu not ready");
        end
        bus.cfg_cpu_ready = 1'b1;
        push_exp(1'b0);
        wait_ready(8, n, seen);
        checks++;
        if (!seen || bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL stall_release: got %b want 01", bus.req_ready);
        end
        bus.req_valid[0] = 1'b0;
        mdl_last = 1'b0;
        wait_done(10, n, seen, g);
        e = exp_q.pop_front();
        checks++;
        if (!seen || bus.req_done !== oh(e.idx) || bus.rsp_data !== e.rsp
            || bus.req_error !== e.err) begin
            errors++;
            $display("FAIL stall_done: got %b/%b/%h want %b/%b/%h", bus.req_done, bus.req_error,
                     bus.rsp_data, oh(e.idx), e.err, e.rsp);
        end
        mdl_rsp = e.rsp;
        mdl_err = e.err;
    endtask

    task automatic test_timeout_stuck();
        int n, g;
        bit seen;
        bit bad;
        done_t e;
        cpu_mode = 2;
        request(1'b0, 8'h66, {32'h9, 32'hA});
        exp_q.push_back('{idx: 1'b0, err: 1'b1, rsp: 64'h0});
        wait_ready(8, n, seen);
        bus.req_valid[0] = 1'b0;
        mdl_last = 1'b0;
        request(1'b1, 8'h77, {32'hB, 32'hC});
        wait_done(40, n, seen, g);
        checks++;
        if (!seen || n != TO + 1 || g != 0) begin
            errors++;
            $display("FAIL stuck_timeout: got %0d cycles %0d grants want %0d/0", n, g, TO + 1);
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.req_done !== oh(e.idx) || bus.req_error !== e.err || bus.rsp_data !== e.rsp) begin
            errors++;
            $display("FAIL stuck_result: got %b/%b/%h want %b/%b/%h", bus.req_done,
                     bus.req_error, bus.rsp_data, oh(e.idx), e.err, e.rsp);
        end
        mdl_rsp = e.rsp;
        mdl_err = e.err;
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (bus.req_ready !== 2'b00 || bus.busy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL recover_hold: got grant or idle want busy with no grant");
        end
        cpu_len = 1;
        cpu_mode = 0;
        push_exp(1'b1);
        wait_ready(10, n, seen);
        checks++;
        if (!seen || bus.req_ready !== 2'b10 || bus.cfg_cmd !== 8'h77) begin
            errors++;
            $display("FAIL recover_usb_grant: got %b/%h want 10/77", bus.req_ready, bus.cfg_cmd);
        end
        bus.req_valid[1] = 1'b0;
        mdl_last = 1'b1;
        wait_done(10, n, seen, g);
        e = exp_q.pop_front();
        checks++;
        if (!seen || bus.req_done !== oh(e.idx) || bus.rsp_data !== e.rsp
            || bus.req_error !== e.err) begin
            errors++;
            $display("FAIL recover_usb_done: got %b/%b/%h want %b/%b/%h", bus.req_done,
                     bus.req_error, bus.rsp_data, oh(e.idx), e.err, e.rsp);
        end
        mdl_rsp = e.rsp;
        mdl_err = e.err;
    endtask

    task automatic test_abort();
        int n, g;
        bit seen;
        bit any_done;
        bit not_busy;
        done_t e;
        cpu_mode = 2;
        request(1'b0, 8'h33, {32'hD, 32'hE});
        wait_ready(8, n, seen);
        checks++;
        if (!seen || bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL abort_grant: got %b want 01", bus.req_ready);
        end
        bus.req_valid[0] = 1'b0;
        mdl_last = 1'b0;
        tick();
        tick();
        bus.n64_abort = 1'b1;
        tick();
        bus.n64_abort = 1'b0;
        any_done = 1'b0;
        not_busy = 1'b0;
        repeat (5) begin
            tick();
            if (bus.req_done !== 2'b00) any_done = 1'b1;
            if (bus.busy !== 1'b1) not_busy = 1'b1;
        end
        checks++;
        if (any_done || not_busy) begin
            errors++;
            $display("FAIL abort_recover: got done %b idle %b want 0/0", any_done, not_busy);
        end
        checks++;
        if (bus.rsp_data !== mdl_rsp || bus.req_error !== mdl_err) begin
            errors++;
            $display("FAIL abort_keep_rsp: got %b/%h want %b/%h", bus.req_error, bus.rsp_data,
                     mdl_err, mdl_rsp);
        end
        cpu_mode = 0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 6) begin
            tick();
            n++;
            if (bus.req_done !== 2'b00) any_done = 1'b1;
        end
        checks++;
        if (bus.busy !== 1'b0 || any_done) begin
            errors++;
            $display("FAIL abort_idle: got busy %b done %b want 0/0", bus.busy, any_done);
        end
        cpu_len = 3;
        request(1'b1, 8'h44, {32'hF, 32'h10});
        push_exp(1'b1);
        wait_ready(8, n, seen);
        bus.req_valid[1] = 1'b0;
        mdl_last = 1'b1;
        bus.n64_abort = 1'b1;
        wait_done(20, n, seen, g);
        e = exp_q.pop_front();
        checks++;
        if (!seen || bus.req_done !== oh(e.idx) || bus.rsp_data !== e.rsp
            || bus.req_error !== e.err) begin
            errors++;
            $display("FAIL abort_usb_ignored: got %b/%b/%h want %b/%b/%h", bus.req_done,
                     bus.req_error, bus.rsp_data, oh(e.idx), e.err, e.rsp);
        end
        mdl_rsp = e.rsp;
        mdl_err = e.err;
        bus.n64_abort = 1'b0;
        tick();
    endtask

    task automatic test_reset_midflight();
        int n, g;
        bit seen;
        done_t e;
        cpu_mode = 2;
        request(1'b0, 8'h5A, {32'h11, 32'h12});
        wait_ready(8, n, seen);
        bus.req_valid[0] = 1'b0;
        mdl_last = 1'b0;
        tick();
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.req_done, bus.req_error, bus.cfg_cmd_request, bus.owner, bus.busy}
            !== 8'h00 || bus.rsp_data !== 64'h0) begin
            errors++;
            $display("FAIL async_reset_ctrl: got %h/%h want 00/0", {bus.req_ready, bus.req_done,
                     bus.req_error, bus.cfg_cmd_request, bus.owner, bus.busy}, bus.rsp_data);
        end
        checks++;
        if ({bus.cfg_cmd, bus.cfg_data} !== 72'h0) begin
            errors++;
            $display("FAIL async_reset_cfg: got %h want 0", {bus.cfg_cmd, bus.cfg_data});
        end
        cpu_mode = 0;
        cpu_len = 1;
        exp_q.delete();
        mdl_last = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        request(1'b0, 8'h12, {32'h21, 32'h22});
        request(1'b1, 8'h13, {32'h31, 32'h32});
        push_exp(~mdl_last);
        wait_ready(8, n, seen);
        checks++;
        if (!seen || bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL reset_n64_first: got %b want 01", bus.req_ready);
        end
        bus.req_valid = 2'b00;
        mdl_last = 1'b0;
        wait_done(10, n, seen, g);
        e = exp_q.pop_front();
        checks++;
        if (!seen || bus.req_done !== oh(e.idx) || bus.rsp_data !== e.rsp) begin
            errors++;
            $display("FAIL reset_done: got %b/%h want %b/%h", bus.req_done, bus.rsp_data,
                     oh(e.idx), e.rsp);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_n64();
        test_timeout_idle();
        test_cpu_not_ready();
        test_timeout_stuck();
        test_abort();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
